// File: rtl/pc_sequencer.sv
// pc_sequencer: boots instruction RAM from the boot ROM, then generates the fetch PC with stall/redirect handling.
// Latency: boot copy has 1-cycle ROM-to-RAM delay; redirects and PC steps appear on pc one cycle later; rel_out is combinational.
// Backpressure: stall holds pc (a redirect overrides it); no backpressure during boot. Optional counters via `PC_SEQ_PERF_EN.
module pc_sequencer #(
   parameter int                XLEN       = 32,
   parameter int                IMEM_AW    = 9,
   parameter int                BOOT_WORDS = 512,
   parameter logic [XLEN-1:0]   RESET_PC   = '0,
   parameter logic [XLEN-1:0]   TRAP_PC    = 32'h0000_0100
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [IMEM_AW-1:0]   rom_addr,
   input  logic [XLEN-1:0]      rom_data,
   output logic                 boot_we,
   output logic [IMEM_AW-1:0]   boot_addr,
   output logic [XLEN-1:0]      boot_data,
   output logic                 boot_done,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic                 redirect_abs,
   input  logic [XLEN-1:0]      ex_pc,
   input  logic [XLEN-1:0]      base,
   input  logic [XLEN-1:0]      imm,
   input  logic                 is_auipc,
   output logic [XLEN-1:0]      pc,
   output logic                 pc_valid,
   output logic [XLEN-1:0]      rel_out,
   output logic                 flush,
   output logic                 misalign_err
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [31:0]          redirect_cnt,
   output logic [31:0]          stall_cnt
`endif
);

   // The counter is one bit wider than the address so it can reach BOOT_WORDS
   // (needed when BOOT_WORDS == 2^IMEM_AW).
   localparam int                 CW       = IMEM_AW + 1;
   localparam logic [CW-1:0]      BOOT_END = CW'(BOOT_WORDS);
   localparam logic [IMEM_AW-1:0] ROM_LAST = IMEM_AW'(BOOT_WORDS - 1);

   typedef enum logic {ST_BOOT, ST_RUN} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   logic                pc_valid_q, pc_valid_d;
   logic                flush_q, flush_d;
   logic                misalign_q, misalign_d;
   logic                boot_done_q, boot_done_d;
   logic                boot_we_q, boot_we_d;
   logic [IMEM_AW-1:0]  boot_addr_q, boot_addr_d;
   logic [XLEN-1:0]     boot_data_q, boot_data_d;

   logic [XLEN-1:0]     sum_rel;
   logic [XLEN-1:0]     sum_abs;
   logic [XLEN-1:0]     target;
   logic                target_ok;

   // Redirect target and auipc/link arithmetic; all sums wrap modulo 2^XLEN.
   always_comb begin
      sum_rel   = ex_pc + imm;
      sum_abs   = (base + imm) & ~XLEN'(1);
      target    = redirect_abs ? sum_abs : sum_rel;
      target_ok = (target[1:0] == 2'b00);
      rel_out   = is_auipc ? sum_rel : (ex_pc + XLEN'(4));
   end

   // ROM address follows the boot counter and parks on the last word once the copy is done.
   always_comb begin
      rom_addr = (cnt_q < BOOT_END) ? cnt_q[IMEM_AW-1:0] : ROM_LAST;
   end

   // Next-state logic: boot copy, then next-PC selection (redirect > stall > increment).
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_d        = pc_q;
      pc_valid_d  = pc_valid_q;
      flush_d     = flush_q;
      misalign_d  = 1'b0;
      boot_done_d = boot_done_q;
      boot_we_d   = 1'b0;
      boot_addr_d = boot_addr_q;
      boot_data_d = boot_data_q;
      case (state_q)
         ST_BOOT: begin
            pc_d    = RESET_PC;
            flush_d = 1'b1;
            if (cnt_q < BOOT_END) begin
               // Word addressed this cycle lands in RAM on the next cycle.
               boot_we_d   = 1'b1;
               boot_addr_d = cnt_q[IMEM_AW-1:0];
               boot_data_d = rom_data;
               cnt_d       = cnt_q + CW'(1);
            end else begin
               state_d     = ST_RUN;
               boot_done_d = 1'b1;
               pc_valid_d  = 1'b1;
               flush_d     = 1'b0;
            end
         end
         ST_RUN: begin
            flush_d = 1'b0;
            if (redirect) begin
               flush_d = 1'b1;
               if (target_ok) begin
                  pc_d = target;
               end else begin
                  pc_d       = TRAP_PC;
                  misalign_d = 1'b1;
               end
            end else if (!stall) begin
               pc_d = pc_q + XLEN'(4);
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State and registered outputs; reset aborts any activity and restarts boot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_BOOT;
         cnt_q       <= '0;
         pc_q        <= RESET_PC;
         pc_valid_q  <= 1'b0;
         flush_q     <= 1'b1;
         misalign_q  <= 1'b0;
         boot_done_q <= 1'b0;
         boot_we_q   <= 1'b0;
         boot_addr_q <= '0;
         boot_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pc_q        <= pc_d;
         pc_valid_q  <= pc_valid_d;
         flush_q     <= flush_d;
         misalign_q  <= misalign_d;
         boot_done_q <= boot_done_d;
         boot_we_q   <= boot_we_d;
         boot_addr_q <= boot_addr_d;
         boot_data_q <= boot_data_d;
      end
   end

   assign pc           = pc_q;
   assign pc_valid     = pc_valid_q;
   assign flush        = flush_q;
   assign misalign_err = misalign_q;
   assign boot_done    = boot_done_q;
   assign boot_we      = boot_we_q;
   assign boot_addr    = boot_addr_q;
   assign boot_data    = boot_data_q;

`ifdef PC_SEQ_PERF_EN
   logic [31:0] redirect_cnt_q, redirect_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating RUN-state event counters; trapped redirects count as redirects.
   always_comb begin
      redirect_cnt_d = redirect_cnt_q;
      stall_cnt_d    = stall_cnt_q;
      if (state_q == ST_RUN) begin
         if (redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
         end
         if (stall && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         redirect_cnt_q <= '0;
         stall_cnt_q    <= '0;
      end else begin
         redirect_cnt_q <= redirect_cnt_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign redirect_cnt = redirect_cnt_q;
   assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer with BOOT_WORDS=4 and a ROM returning 10+addr.
// A cycle-level model derived from the behavioural rules is compared every cycle,
// with literal expectations pinning the key points of the scenario.
module tb_pc_sequencer;
   localparam int          XLEN = 32;
   localparam int          AW   = 9;
   localparam int          BW   = 4;
   localparam logic [31:0] RPC  = 32'h0;
   localparam logic [31:0] TPC  = 32'h0000_0100;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_data;
   logic          boot_we;
   logic [AW-1:0] boot_addr;
   logic [31:0]   boot_data;
   logic          boot_done;
   logic          stall, redirect, redirect_abs, is_auipc;
   logic [31:0]   ex_pc, base, imm;
   logic [31:0]   pc;
   logic          pc_valid;
   logic [31:0]   rel_out;
   logic          flush;
   logic          misalign_err;
`ifdef PC_SEQ_PERF_EN
   logic [31:0]   redirect_cnt, stall_cnt;
`endif

   pc_sequencer #(
      .XLEN(XLEN), .IMEM_AW(AW), .BOOT_WORDS(BW), .RESET_PC(RPC), .TRAP_PC(TPC)
   ) dut (
      .clk(clk), .reset(reset),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .boot_we(boot_we), .boot_addr(boot_addr), .boot_data(boot_data), .boot_done(boot_done),
      .stall(stall), .redirect(redirect), .redirect_abs(redirect_abs),
      .ex_pc(ex_pc), .base(base), .imm(imm), .is_auipc(is_auipc),
      .pc(pc), .pc_valid(pc_valid), .rel_out(rel_out), .flush(flush), .misalign_err(misalign_err)
`ifdef PC_SEQ_PERF_EN
      , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
   );

   // Boot ROM content: word at address a holds 10+a.
   assign rom_data = 32'd10 + 32'(rom_addr);

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: cycles since reset release, and expected registered outputs.
   int          c;
   logic [31:0] m_pc;
   logic        m_flush;
   logic        m_mis;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [31:0] exp_rel;
      exp_rel = is_auipc ? (ex_pc + imm) : (ex_pc + 32'd4);
      chk("rel_out", rel_out, exp_rel);
      chk("rom_addr", 32'(rom_addr), (c < BW) ? 32'(c) : 32'(BW - 1));
      chk("boot_we", 32'(boot_we), 32'((c >= 1) && (c <= BW)));
      if ((c >= 1) && (c <= BW)) begin
         chk("boot_addr", 32'(boot_addr), 32'(c - 1));
         chk("boot_data", boot_data, 32'(10 + c - 1));
      end else if (c == 0) begin
         chk("boot_addr", 32'(boot_addr), 32'd0);
         chk("boot_data", boot_data, 32'd0);
      end
      chk("boot_done", 32'(boot_done), 32'(c > BW));
      chk("pc_valid", 32'(pc_valid), 32'(c > BW));
      chk("pc", pc, m_pc);
      chk("flush", 32'(flush), 32'(m_flush));
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
   endtask

   // Advance the model across one rising edge using the inputs of the current cycle.
   task automatic model_next();
      logic [31:0] t;
      if (c <= BW) begin
         m_pc    = RPC;
         m_flush = (c < BW);
         m_mis   = 1'b0;
      end else if (redirect) begin
         t = redirect_abs ? ((base + imm) & 32'hFFFF_FFFE) : (ex_pc + imm);
         if ((t % 4) == 0) begin
            m_pc  = t;
            m_mis = 1'b0;
         end else begin
            m_pc  = TPC;
            m_mis = 1'b1;
         end
         m_flush = 1'b1;
      end else if (stall) begin
         m_flush = 1'b0;
         m_mis   = 1'b0;
      end else begin
         m_pc    = m_pc + 32'd4;
         m_flush = 1'b0;
         m_mis   = 1'b0;
      end
      c++;
   endtask

   // One cycle: drive inputs just after the falling edge, check, update model, move to next falling edge.
   task automatic step(input logic st, input logic rd, input logic ab,
                       input logic [31:0] ep, input logic [31:0] bs, input logic [31:0] im,
                       input logic au);
      stall = st; redirect = rd; redirect_abs = ab;
      ex_pc = ep; base = bs; imm = im; is_auipc = au;
      #1;
      compare_all();
      model_next();
      @(negedge clk);
   endtask

   task automatic free(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   // Assert reset asynchronously, check reset values, then release on a falling edge.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst pc", pc, RPC);
      chk("rst pc_valid", 32'(pc_valid), 32'd0);
      chk("rst boot_we", 32'(boot_we), 32'd0);
      chk("rst boot_addr", 32'(boot_addr), 32'd0);
      chk("rst boot_data", boot_data, 32'd0);
      chk("rst boot_done", 32'(boot_done), 32'd0);
      chk("rst misalign_err", 32'(misalign_err), 32'd0);
      chk("rst flush", 32'(flush), 32'd1);
      chk("rst rom_addr", 32'(rom_addr), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b1;
      c       = 0;
      m_pc    = RPC;
      m_flush = 1'b1;
      m_mis   = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0; redirect = 1'b0; redirect_abs = 1'b0; is_auipc = 1'b0;
      ex_pc = 32'h0; base = 32'h0; imm = 32'h0;
      c = 0; m_pc = RPC; m_flush = 1'b1; m_mis = 1'b0;
      #2;
      do_reset();

      // Boot with stall/redirect noise, which must be ignored.
      step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h3, 1'b1);
      chk("boot1 we", 32'(boot_we), 32'd1);
      chk("boot1 addr", 32'(boot_addr), 32'd0);
      chk("boot1 data", boot_data, 32'd10);
      step(1'b0, 1'b1, 1'b1, 32'h0, 32'h101, 32'h2, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h10, 1'b0);
      chk("boot4 addr", 32'(boot_addr), 32'd3);
      chk("boot4 data", boot_data, 32'd13);
      step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h10, 1'b0);
      chk("run0 boot_done", 32'(boot_done), 32'd1);
      chk("run0 pc", pc, 32'h0);
      chk("run0 flush", 32'(flush), 32'd0);

      // Free-running increment.
      free(3);
      chk("seq pc", pc, 32'd12);

      // Relative branch ex_pc=0x40, imm=-8.
      step(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hFFFF_FFF8, 1'b0);
      chk("rel target pc", pc, 32'h38);
      chk("rel target flush", 32'(flush), 32'd1);
      is_auipc = 1'b1; ex_pc = 32'h40; imm = 32'hFFFF_FFF8;
      #1;
      chk("auipc rel_out", rel_out, 32'h38);
      is_auipc = 1'b0;
      #1;
      chk("link rel_out", rel_out, 32'h44);
      step(1'b0, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h24, 1'b1);
      chk("after rel flush", 32'(flush), 32'd0);
      chk("after rel pc", pc, 32'h3C);

      // jalr to a misaligned target traps.
      step(1'b0, 1'b1, 1'b1, 32'h0, 32'h101, 32'h2, 1'b0);
      chk("trap pc", pc, TPC);
      chk("trap misalign", 32'(misalign_err), 32'd1);
      chk("trap flush", 32'(flush), 32'd1);
      free(1);
      chk("trap pulse end", 32'(misalign_err), 32'd0);
      chk("trap next pc", pc, 32'h104);

      // Redirect beats stall; then stall alone holds.
      step(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'h10, 1'b0);
      chk("stall+redirect pc", pc, 32'h210);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      chk("stall hold pc", pc, 32'h210);
      chk("stall flush", 32'(flush), 32'd0);

      // Back-to-back redirects.
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h80, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h0, 32'h300, 32'h1, 1'b0);
      chk("b2b pc", pc, 32'h300);
      chk("b2b flush", 32'(flush), 32'd1);
      free(1);

      // PC wrap and target-sum wrap, then a misaligned relative target.
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0);
      chk("top pc", pc, 32'hFFFF_FFFC);
      free(1);
      chk("wrap pc", pc, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h20, 1'b1);
      chk("sum wrap pc", pc, 32'h10);
      step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h2, 1'b0);
      free(2);

      // Reset in the middle of RUN restarts boot.
      do_reset();
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      chk("midboot rom_addr", 32'(rom_addr), 32'd2);

      // Reset at word 2 of boot.
      do_reset();
      chk("reboot rom_addr", 32'(rom_addr), 32'd0);
      free(BW + 1);
      chk("reboot done", 32'(boot_done), 32'd1);
      free(3);
      chk("reboot pc", pc, 32'd12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
